// File: rtl/lfsr_prbs_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_prbs_gen_if
//  Description : Beat output channel of the PRBS generator. The generator
//                drives a W-bit beat with a valid flag; the consumer answers
//                with ready. A beat is transferred on a clock edge where
//                out_valid and out_ready are both high.
//                  out_valid  master->slave  beat available
//                  out_data   master->slave  W beat bits, first bit in MSB
//                  out_ready  slave->master  consumer accepts the beat
//  Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_prbs_gen_if #(
    parameter int W = 8
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_prbs_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_prbs_gen
//  Description : Programmable PRBS source. An N-bit LFSR in Fibonacci or
//                Galois form advances W steps per accepted beat and presents
//                the W generated bits on a valid/ready channel.
//  Ports       : clk       rising-edge clock
//                rst_n     asynchronous active-low reset
//                load      strobe: latch seed / mask / galois (IDLE only)
//                seed      initial LFSR state (zero is replaced)
//                mask      tap mask, bit i = tap on state bit i
//                galois    0 = Fibonacci, 1 = Galois
//                start     begin generation from the current state
//                stop      end generation after the pending beat
//                prbs      beat channel (out_valid / out_data / out_ready)
//                busy      generator not idle
//                lockup    sticky: a zero seed was replaced
//                load_err  one-cycle pulse: load attempted while busy
//                beat_cnt  accepted beats, wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_prbs_gen #(
    parameter int             N            = 32,
    parameter int             W            = 8,
    parameter logic [N-1:0]   DEFAULT_SEED = N'(1),
    parameter int             CNT_W        = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [N-1:0]     seed,
    input  wire logic [N-1:0]     mask,
    input  wire logic             galois,
    input  wire logic             start,
    input  wire logic             stop,
    lfsr_prbs_gen_if.master       prbs,
    output logic                  busy,
    output logic                  lockup,
    output logic                  load_err,
    output logic [CNT_W-1:0]      beat_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [N-1:0]       s_q,        s_d;
    logic [N-1:0]       m_q,        m_d;
    logic               g_q,        g_d;
    logic [W-1:0]       data_q,     data_d;
    logic               valid_q,    valid_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               lockup_q,   lockup_d;
    logic               load_err_q, load_err_d;

    // Next beat and the state after it, always computed from the current
    // state so a new beat can be registered on the same edge as a handshake.
    logic [W-1:0]       beat_bits;
    logic [N-1:0]       beat_state;

    always_comb begin
        logic [N-1:0] st;
        logic [W-1:0] bits;
        st   = s_q;
        bits = '0;
        for (int k = 0; k < W; k++) begin
            // Shift each new bit in at the LSB so step 0 ends up in the MSB.
            bits = W'({bits, st[N-1]});
            if (g_q) begin
                st = {st[N-2:0], 1'b0} ^ (st[N-1] ? m_q : '0);
            end else begin
                st = {st[N-2:0], ^(st & m_q)};
            end
        end
        beat_bits  = bits;
        beat_state = st;
    end

    logic handshake;
    assign handshake = valid_q & prbs.out_ready;

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        m_d        = m_q;
        g_d        = g_q;
        data_d     = data_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        lockup_d   = lockup_q;
        load_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // load takes priority over a simultaneous start
                if (load) begin
                    m_d = mask;
                    g_d = galois;
                    if (seed == '0) begin
                        s_d      = DEFAULT_SEED;
                        lockup_d = 1'b1;
                    end else begin
                        s_d      = seed;
                        lockup_d = 1'b0;
                    end
                end else if (start) begin
                    data_d  = beat_bits;
                    s_d     = beat_state;
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                load_err_d = load;
                if (handshake) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (stop) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        data_d = beat_bits;
                        s_d    = beat_state;
                    end
                end else if (stop) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                load_err_d = load;
                if (handshake) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            m_q        <= '0;
            g_q        <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            lockup_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            m_q        <= m_d;
            g_q        <= g_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            lockup_q   <= lockup_d;
            load_err_q <= load_err_d;
        end
    end

    assign prbs.out_valid = valid_q;
    assign prbs.out_data  = data_q;
    assign busy           = (state_q != ST_IDLE);
    assign lockup         = lockup_q;
    assign load_err       = load_err_q;
    assign beat_cnt       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prbs_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_prbs_gen
//  Description : Bench for lfsr_prbs_gen. Two 4-bit generators (1 and 4 bits
//                per beat) share their control inputs and have independent
//                ready lines; each is compared every cycle against an
//                arithmetic reference of the LFSR and its handshake rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_prbs_gen;
    localparam int         N     = 4;
    localparam int         CNT_W = 16;
    localparam logic [3:0] DSEED = 4'b0110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, load, galois, start, stop;
    logic [N-1:0]     seed, mask;
    logic             busy1, lockup1, load_err1, busy4, lockup4, load_err4;
    logic [CNT_W-1:0] cnt1, cnt4;

    lfsr_prbs_gen_if #(.W(1)) if1 ();
    lfsr_prbs_gen_if #(.W(4)) if4 ();

    lfsr_prbs_gen #(.N(N), .W(1), .DEFAULT_SEED(DSEED), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .seed(seed), .mask(mask),
        .galois(galois), .start(start), .stop(stop), .prbs(if1),
        .busy(busy1), .lockup(lockup1), .load_err(load_err1), .beat_cnt(cnt1)
    );

    lfsr_prbs_gen #(.N(N), .W(4), .DEFAULT_SEED(DSEED), .CNT_W(CNT_W)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load), .seed(seed), .mask(mask),
        .galois(galois), .start(start), .stop(stop), .prbs(if4),
        .busy(busy4), .lockup(lockup4), .load_err(load_err4), .beat_cnt(cnt4)
    );

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    logic [3:0] rm, s1, s4, cur1, cur4;
    logic       rg, v1, v4, d1, d4, lk, le;
    int         c1, c4;

    // State after one step: doubling drops the old MSB; Fibonacci appends
    // the parity of the tapped bits, Galois folds the mask in when the
    // dropped bit was one.
    function automatic logic [3:0] ref_next(input logic [3:0] s, input logic [3:0] m,
                                            input logic g);
        if (g) return 4'(s * 2) ^ ((s >= 4'd8) ? m : 4'd0);
        return 4'(s * 2) + 4'($countones(s & m) % 2);
    endfunction

    function automatic logic [3:0] ref_bits(input logic [3:0] s, input logic [3:0] m,
                                            input logic g, input int w);
        logic [3:0] r = 4'd0;
        logic [3:0] t = s;
        for (int k = 0; k < w; k++) begin
            r = 4'(r * 2 + ((t >= 4'd8) ? 1 : 0));
            t = ref_next(t, m, g);
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_adv(input logic [3:0] s, input logic [3:0] m,
                                           input logic g, input int w);
        logic [3:0] t = s;
        for (int k = 0; k < w; k++) t = ref_next(t, m, g);
        return t;
    endfunction

    task automatic m_reset();
        s1 = 0; s4 = 0; rm = 0; rg = 0; cur1 = 0; cur4 = 0;
        v1 = 0; v4 = 0; d1 = 0; d4 = 0; c1 = 0; c4 = 0; lk = 0; le = 0;
    endtask

    task automatic m_load(input logic [3:0] sd, input logic [3:0] mk, input logic g);
        s1 = (sd == 0) ? DSEED : sd;
        s4 = s1; rm = mk; rg = g; lk = (sd == 0);
    endtask

    task automatic m_start();
        cur1 = ref_bits(s1, rm, rg, 1); s1 = ref_adv(s1, rm, rg, 1);
        cur4 = ref_bits(s4, rm, rg, 4); s4 = ref_adv(s4, rm, rg, 4);
        v1 = 1; v4 = 1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid1"}, if1.out_valid, v1);
        chk({tag, ".data1"},  if1.out_data,  cur1);
        chk({tag, ".cnt1"},   cnt1,          c1);
        chk({tag, ".busy1"},  busy1,         v1);
        chk({tag, ".valid4"}, if4.out_valid, v4);
        chk({tag, ".data4"},  if4.out_data,  cur4);
        chk({tag, ".cnt4"},   cnt4,          c4);
        chk({tag, ".busy4"},  busy4,         v4);
        chk({tag, ".lockup"}, {lockup4, lockup1}, {lk, lk});
        chk({tag, ".lderr"},  {load_err4, load_err1}, {le, le});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] sd, input logic [3:0] mk, input logic g,
                           input string tag);
        seed = sd; mask = mk; galois = g; load = 1'b1;
        tick();
        load = 1'b0;
        m_load(sd, mk, g);
        le = 0;
        chk_all(tag);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_start();
        le = 0;
        chk_all(tag);
    endtask

    // One clock with the given ready lines, stop and load; the model
    // retires a beat on a handshake and either produces the next one or,
    // if stop is pending, returns to idle.
    task automatic cycle(input logic r1, input logic r4, input logic stp, input logic ld,
                         input string tag);
        if1.out_ready = r1; if4.out_ready = r4; stop = stp; load = ld;
        if (ld) seed = 4'($urandom_range(0, 15));
        tick();
        stop = 1'b0; load = 1'b0;
        le = ld && v1;
        if (v1) begin
            if (r1) begin
                c1++;
                if (stp || d1) begin v1 = 0; d1 = 0; end
                else begin cur1 = ref_bits(s1, rm, rg, 1); s1 = ref_adv(s1, rm, rg, 1); end
            end else if (stp) d1 = 1;
        end
        if (v4) begin
            if (r4) begin
                c4++;
                if (stp || d4) begin v4 = 0; d4 = 0; end
                else begin cur4 = ref_bits(s4, rm, rg, 4); s4 = ref_adv(s4, rm, rg, 4); end
            end else if (stp) d4 = 1;
        end
        chk_all(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fib_first;
        logic [6:0] gal_first;
        fib_first = 4'b0001;
        gal_first = 7'b0001001;

        rst_n = 0; load = 0; start = 0; stop = 0; seed = 0; mask = 0; galois = 0;
        if1.out_ready = 0; if4.out_ready = 0;
        m_reset();
        repeat (3) tick();
        chk_all("reset");
        rst_n = 1;
        tick();

        // Fibonacci x^4+x+1, 15-beat period
        do_load(4'b0001, 4'b1001, 1'b0, "fib_load");
        do_start("fib_start");
        chk("fib_w4_first_beat", if4.out_data, 4'b0001);
        for (int i = 0; i < 15; i++) begin
            if (i < 4) chk("fib_w1_first_bits", if1.out_data, fib_first[3-i]);
            cycle(1, 1, 0, 0, "fib_run");
        end
        chk("fib_cnt_after_15", cnt1, 15);
        chk("fib_period_bit", if1.out_data, 0);
        cycle(1, 1, 1, 0, "fib_stop");

        // Galois form, same polynomial in Galois taps
        do_load(4'b0001, 4'b0011, 1'b1, "gal_load");
        do_start("gal_start");
        for (int i = 0; i < 7; i++) begin
            chk("gal_w1_bits", if1.out_data, gal_first[6-i]);
            cycle(1, 1, 0, 0, "gal_run");
        end
        cycle(1, 1, 1, 0, "gal_stop");

        // Backpressure, stop while stalled, then drain
        do_start("bp_start");
        cycle(1, 1, 0, 0, "bp_run");
        cycle(1, 1, 0, 0, "bp_run");
        for (int i = 0; i < 5; i++) cycle(0, 0, (i == 2), 0, "bp_stall");
        cycle(1, 1, 0, 0, "bp_drain");
        cycle(1, 1, 0, 0, "bp_idle");

        // Randomised runs in both forms, with a load attempted while running
        for (int g = 0; g < 2; g++) begin
            do_load(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), g[0], "rnd_load");
            do_start("rnd_start");
            for (int i = 0; i < 60; i++) begin
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, (i == 20),
                      "rnd_run");
            end
            cycle(1, 1, 1, 0, "rnd_stop");
        end

        // Zero seed is replaced and flagged; a non-zero seed clears the flag
        do_load(4'b0000, 4'b1001, 1'b0, "lock_load");
        chk("lockup_set", lockup1, 1'b1);
        do_start("lock_start");
        cycle(1, 1, 1, 0, "lock_stop");
        do_load(4'b0101, 4'b1001, 1'b0, "unlock_load");
        chk("lockup_clear", lockup4, 1'b0);

        // load together with start: load wins, no generation
        seed = 4'b0011; load = 1; start = 1;
        tick();
        load = 0; start = 0;
        m_load(4'b0011, 4'b1001, 1'b0);
        chk_all("load_start");
        do_start("after_load_start");

        // Asynchronous reset between edges while running
        cycle(1, 1, 0, 0, "pre_reset");
        #3;
        rst_n = 0;
        #1;
        m_reset();
        chk_all("async_reset");
        tick();
        rst_n = 1;
        tick();
        chk_all("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lfsr_prbs_gen.md
Name: lfsr_prbs_gen

Overview:
- Parametrised, programmable PRBS source. Successor to the single-mode, one-bit-per-cycle LFSR.
- Adds selectable Fibonacci/Galois form, W output bits per beat, and a valid/ready output handshake.
- Adds run/stop control, all-zero lock-up recovery and an accepted-beat counter.
- Drives randomised stimulus into the core test harness (instruction/data fuzzing).

Parameters:
- N, 32: LFSR state width; legal range 3..64.
- W, 8: output bits per beat (LFSR steps per accepted beat); legal range 1..N.
- DEFAULT_SEED, 1: substitute seed when the loaded seed is all-zero; must be non-zero.
- CNT_W, 32: width of the beat counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe that latches seed, mask and galois.
- seed  in  N  initial state.
- mask  in  N  tap mask; bit i set means tap on state bit i.
- galois  in  1  0 = Fibonacci, 1 = Galois.
- start  in  1  begin generation.
- stop  in  1  end generation after the pending beat.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  W  beat bits; the first-generated bit is in the MSB.
- busy  out  1  FSM is not in IDLE.
- lockup  out  1  sticky flag: a zero seed was replaced.
- load_err  out  1  one-cycle pulse: load was attempted while busy.
- beat_cnt  out  CNT_W  count of accepted beats; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release) clears state S, mask register M, galois register G, out_data, beat_cnt, lockup and load_err; out_valid=0; FSM=IDLE.
- One step, both forms:
  - Output bit = S[N-1] before the step.
  - Fibonacci: fb = XOR over i of (M[i] & S[i]); S <= {S[N-2:0], fb}.
  - Galois: fb = S[N-1]; S <= {S[N-2:0], 1'b0} ^ (fb ? M : 0).
- A beat performs W steps combinationally within one cycle. out_data[W-1] is step 0's bit, out_data[0] is step W-1's bit. S advances by W steps.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - load: S<=seed, M<=mask, G<=galois. If seed==0, S<=DEFAULT_SEED and lockup<=1.
  - start without load: compute the first beat into out_data, out_valid<=1, go to RUN. The first beat is visible the cycle after start.
  - load and start in the same cycle: load wins and start is ignored.
  - start with no prior load: generates from S=0, which stays all-zero (degenerate, permitted).
- RUN:
  - Handshake (out_valid & out_ready) with stop=0: next beat registered the same edge, out_valid stays 1, beat_cnt+1. Full throughput is one beat per cycle.
  - out_valid=1 & out_ready=0: out_data, S and beat_cnt are held stable. out_valid never drops without a handshake.
  - stop & handshake: beat_cnt+1, out_valid<=0, go to IDLE.
  - stop without handshake: go to DRAIN.
- DRAIN: hold the beat until the handshake, then beat_cnt+1, out_valid<=0, go to IDLE. start and stop are ignored.
- load in RUN or DRAIN: ignored; load_err pulses for 1 cycle; registers are unchanged.
- busy = (FSM != IDLE).
- lockup clears only on reset or on a load with a non-zero seed.
- A new start from IDLE continues from the current S; a sequence restarts only via load.
- beat_cnt is not cleared by load or start.
- Reset asserted mid-beat: outputs go to reset values immediately; the in-flight beat is discarded.

Test Plan:
- Fibonacci, N=4, W=1, seed=4'b0001, mask=4'b1001, start, out_ready=1 -> out_data 0,0,0,1,...; S sequence 0011,0111,1111,1110; S returns to 0001 after 15 beats; beat_cnt=15.
- Same configuration, W=4 -> first beat out_data=4'b0001, then S=4'b1110; the beat is visible exactly 1 cycle after start.
- Galois, N=4, W=1, seed=4'b0001, mask=4'b0011 -> S sequence 0010,0100,1000,0011,0110,1100,1011; outputs 0,0,0,1,0,0,1; period 15.
- Backpressure: hold out_ready=0 for 5 cycles mid-run -> out_data, out_valid and beat_cnt stable. Assert stop during the stall -> DRAIN. Release ready -> exactly one more handshake, then out_valid=0 and busy=0.
- Load seed=0 -> S=DEFAULT_SEED and lockup=1. Later load seed=4'b0101 -> lockup=0. Load during RUN -> load_err pulses 1 cycle and the sequence is unaffected. load+start together in IDLE -> stays IDLE.
- Assert rst_n low asynchronously between clock edges while RUN -> out_valid, busy and beat_cnt go to 0 without waiting for a clock edge.
